// File: rtl/uf_pkg.sv
// Shared definitions for the union/find engine: request opcodes, FSM states
// and the bit layout of the packed request word {op, node_a, node_b}.
package uf_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_UNION = 2'b01;
    localparam logic [1:0] OP_FIND  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        FETCH,
        WALK_A,
        WALK_B,
        LINK,
        RESP
    } uf_state_t;

    // Request word: op in the two MSBs, then node_a, then node_b at bit 0.
    localparam int B_LSB = 0;

    function automatic int uf_a_lsb(input int addr_width);
        return addr_width;
    endfunction

    function automatic int uf_op_lsb(input int addr_width);
        return 2 * addr_width;
    endfunction

endpackage

// File: rtl/uf_parent_ram.sv
// Parent table storage: one synchronous read port (1-cycle latency) and one
// write port, written so it maps onto a simple dual-port block RAM.
module uf_parent_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int N          = 256
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] wr_data
);

    logic [ADDR_WIDTH-1:0] mem [N];

    // Registered read and single write port; no reset so it infers block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/union_find_engine.sv
// Union/find request consumer. Pops one request at a time from the request
// FIFO, walks the parent table to the root(s), links larger root under the
// smaller one for UNION, and emits one result strobe per FIND/UNION.
module union_find_engine
    import uf_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int N          = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    input  logic [2*ADDR_WIDTH+1:0] fifo_rdata,
    output logic                    res_valid,
    output logic [1:0]              res_op,
    output logic [ADDR_WIDTH-1:0]   res_node,
    output logic [ADDR_WIDTH-1:0]   res_root,
    output logic                    busy,
    output logic                    err,
    input  logic                    err_clr
);

    localparam int OP_LSB = uf_op_lsb(ADDR_WIDTH);
    localparam int A_LSB  = uf_a_lsb(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   N_EXT    = (ADDR_WIDTH+1)'(N);
    localparam logic [ADDR_WIDTH:0]   HOP_MAX  = (ADDR_WIDTH+1)'(N - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);

    uf_state_t             state;
    logic [1:0]            op_q;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [ADDR_WIDTH-1:0] b_q;
    logic [ADDR_WIDTH-1:0] cur;
    logic [ADDR_WIDTH-1:0] ra;
    logic [ADDR_WIDTH-1:0] rb;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [ADDR_WIDTH:0]   hops;

    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [ADDR_WIDTH-1:0] ram_rd_data;
    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic [ADDR_WIDTH-1:0] ram_wr_data;

    logic [1:0]            in_op;
    logic [ADDR_WIDTH-1:0] in_a;
    logic [ADDR_WIDTH-1:0] in_b;
    logic                  in_range;
    logic                  at_root;
    logic                  background;
    logic [ADDR_WIDTH-1:0] root_lo;
    logic [ADDR_WIDTH-1:0] root_hi;

    assign in_op      = fifo_rdata[OP_LSB +: 2];
    assign in_a       = fifo_rdata[A_LSB +: ADDR_WIDTH];
    assign in_b       = fifo_rdata[B_LSB +: ADDR_WIDTH];
    assign in_range   = ({1'b0, in_a} < N_EXT) && ({1'b0, in_b} < N_EXT);
    // RAM output is the parent of cur during either walk
    assign at_root    = (ram_rd_data == cur);
    // Label 0 is the background; unions touching it never modify the table
    assign background = (a_q == '0) || (b_q == '0);
    assign root_lo    = (ra < rb) ? ra : rb;
    assign root_hi    = (ra < rb) ? rb : ra;

    uf_parent_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .N          (N)
    ) u_parent_ram (
        .clk     (clk),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data)
    );

    // Read address: node a on fetch, next hop during walks, b when walk A ends
    always_comb begin
        ram_rd_addr = cur;
        case (state)
            FETCH:   ram_rd_addr = in_range ? in_a : '0;
            WALK_A:  ram_rd_addr = at_root ? b_q : ram_rd_data;
            WALK_B:  ram_rd_addr = ram_rd_data;
            default: ram_rd_addr = cur;
        endcase
    end

    // Write port: identity fill while clearing, root link for a real union
    always_comb begin
        ram_wr_en   = 1'b0;
        ram_wr_addr = clr_cnt;
        ram_wr_data = clr_cnt;
        if (state == CLEAR) begin
            ram_wr_en = 1'b1;
        end else if (state == LINK && ra != rb && !background) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = root_hi;
            ram_wr_data = root_lo;
        end
    end

    // Control FSM with registered outputs; a reset always restarts the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            fifo_rd_en <= 1'b0;
            res_valid  <= 1'b0;
            res_op     <= '0;
            res_node   <= '0;
            res_root   <= '0;
            busy       <= 1'b1;
            err        <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cur        <= '0;
            ra         <= '0;
            rb         <= '0;
            hops       <= '0;
        end else begin
            res_valid  <= 1'b0;
            fifo_rd_en <= 1'b0;
            // A new error later in this block overrides the clear
            if (err_clr) begin
                err <= 1'b0;
            end
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_IDX) begin
                        clr_cnt <= '0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    // First FETCH cycle is the pop strobe; the word lands the cycle after
                    if (!fifo_rd_en) begin
                        op_q <= in_op;
                        a_q  <= in_a;
                        b_q  <= in_b;
                        cur  <= in_a;
                        hops <= '0;
                        if ((in_op == OP_UNION || in_op == OP_FIND) && !in_range) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            case (in_op)
                                OP_NOP: begin
                                    busy  <= 1'b0;
                                    state <= IDLE;
                                end
                                OP_CLEAR: state <= CLEAR;
                                default:  state <= WALK_A;
                            endcase
                        end
                    end
                end
                WALK_A: begin
                    if (at_root) begin
                        ra <= cur;
                        if (op_q == OP_FIND) begin
                            res_valid <= 1'b1;
                            res_op    <= op_q;
                            res_node  <= a_q;
                            res_root  <= cur;
                            state     <= RESP;
                        end else begin
                            cur   <= b_q;
                            hops  <= '0;
                            state <= WALK_B;
                        end
                    end else if (hops == HOP_MAX) begin
                        err       <= 1'b1;
                        res_valid <= 1'b1;
                        res_op    <= op_q;
                        res_node  <= a_q;
                        res_root  <= '0;
                        state     <= RESP;
                    end else begin
                        cur  <= ram_rd_data;
                        hops <= hops + 1'b1;
                    end
                end
                WALK_B: begin
                    if (at_root) begin
                        rb    <= cur;
                        state <= LINK;
                    end else if (hops == HOP_MAX) begin
                        err       <= 1'b1;
                        res_valid <= 1'b1;
                        res_op    <= op_q;
                        res_node  <= a_q;
                        res_root  <= '0;
                        state     <= RESP;
                    end else begin
                        cur  <= ram_rd_data;
                        hops <= hops + 1'b1;
                    end
                end
                LINK: begin
                    res_valid <= 1'b1;
                    res_op    <= op_q;
                    res_node  <= a_q;
                    res_root  <= background ? '0 : root_lo;
                    state     <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    clr_cnt <= '0;
                    busy    <= 1'b1;
                    state   <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_union_find_engine.sv
// Bench for union_find_engine: directed scenarios plus a random request
// stream, all checked against a plain-array union/find model.
module tb_union_find_engine;
    import uf_pkg::*;

    localparam int AW = 8;
    localparam int N  = 200;
    localparam int SETTLE_LIMIT = 10 * N + 50;

    typedef struct {
        int responds;
        int op;
        int node;
        int root;
        int lat;
    } exp_t;

    typedef struct {
        int op;
        int node;
        int root;
        int cyc;
    } resp_t;

    logic            clk;
    logic            rst_n;
    logic            fifo_empty;
    logic            fifo_rd_en;
    logic [2*AW+1:0] fifo_rdata;
    logic            res_valid;
    logic [1:0]      res_op;
    logic [AW-1:0]   res_node;
    logic [AW-1:0]   res_root;
    logic            busy;
    logic            err;
    logic            err_clr;

    union_find_engine #(
        .ADDR_WIDTH (AW),
        .N          (N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_rdata (fifo_rdata),
        .res_valid  (res_valid),
        .res_op     (res_op),
        .res_node   (res_node),
        .res_root   (res_root),
        .busy       (busy),
        .err        (err),
        .err_clr    (err_clr)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [2*AW+1:0] fq[$];
    int              rd_q[$];
    resp_t           resp_q[$];
    exp_t            exp_q[$];

    int par[N];
    bit m_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Request FIFO: data appears the cycle after the pop strobe
    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0) begin
            fifo_rdata <= fq.pop_front();
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Record pops and results away from the active edge
    always @(negedge clk) begin
        if (fifo_rd_en) rd_q.push_back(cyc);
        if (res_valid) resp_q.push_back('{int'(res_op), int'(res_node), int'(res_root), cyc});
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic void m_clear();
        for (int i = 0; i < N; i++) par[i] = i;
    endfunction

    function automatic int m_root(input int x, output int h);
        int y;
        y = x;
        h = 0;
        while (par[y] != y) begin
            y = par[y];
            h++;
        end
        return y;
    endfunction

    // Apply one request to the model and queue it for the FIFO
    task automatic send(input int op, input int a, input int b);
        exp_t e;
        int ra, rb, ha, hb, lo, hi;
        e.responds = 0;
        e.op = op;
        e.node = a;
        e.root = 0;
        e.lat = 0;
        if ((op == int'(OP_UNION) || op == int'(OP_FIND)) && (a >= N || b >= N)) begin
            m_err = 1'b1;
        end else if (op == int'(OP_CLEAR)) begin
            m_clear();
        end else if (op == int'(OP_FIND)) begin
            ra = m_root(a, ha);
            e.responds = 1;
            e.root = ra;
            e.lat = 3 + ha;
        end else if (op == int'(OP_UNION)) begin
            ra = m_root(a, ha);
            rb = m_root(b, hb);
            e.responds = 1;
            e.lat = 5 + ha + hb;
            lo = (ra < rb) ? ra : rb;
            hi = (ra < rb) ? rb : ra;
            if (a == 0 || b == 0) begin
                e.root = 0;
            end else begin
                if (ra != rb) par[hi] = lo;
                e.root = lo;
            end
        end
        exp_q.push_back(e);
        fq.push_back({op[1:0], a[AW-1:0], b[AW-1:0]});
        fifo_empty = 1'b0;
    endtask

    // Wait for the engine to drain everything, then score all queued requests
    task automatic settle();
        int n;
        int n_resp;
        int rc;
        exp_t e;
        resp_t r;
        n = 0;
        while (!(fq.size() == 0 && !busy && !fifo_rd_en) && n < SETTLE_LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("settle_in_time", int'(n < SETTLE_LIMIT), 1);
        n_resp = 0;
        foreach (exp_q[i]) n_resp += exp_q[i].responds;
        chk("pop_count", rd_q.size(), exp_q.size());
        chk("resp_count", resp_q.size(), n_resp);
        if (rd_q.size() == exp_q.size() && resp_q.size() == n_resp) begin
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                rc = rd_q.pop_front();
                if (e.responds != 0) begin
                    r = resp_q.pop_front();
                    chk("res_op", r.op, e.op);
                    chk("res_node", r.node, e.node);
                    chk("res_root", r.root, e.root);
                    chk("latency", r.cyc - rc, e.lat);
                end
            end
        end
        exp_q.delete();
        rd_q.delete();
        resp_q.delete();
        chk("err_flag", int'(err), int'(m_err));
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err = 1'b0;
        chk("err_after_clr", int'(err), 0);
    endtask

    // Release happens at a negedge; count edges until busy drops
    task automatic count_clear(input string tag);
        int n;
        n = 0;
        while (n < 4 * N) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!busy) break;
        end
        chk(tag, n, N);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, op, a, b, k, nreq;
        rst_n      = 1'b0;
        err_clr    = 1'b0;
        fifo_empty = 1'b1;
        fifo_rdata = '0;
        m_clear();
        m_err = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_fifo_rd_en", int'(fifo_rd_en), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_op", int'(res_op), 0);
        chk("rst_res_node", int'(res_node), 0);
        chk("rst_res_root", int'(res_root), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_busy", int'(busy), 1);

        rst_n = 1'b1;
        count_clear("clear_cycles");

        // Directed scenarios
        send(int'(OP_FIND), 5, 0);   settle();
        send(int'(OP_UNION), 7, 3);  settle();
        send(int'(OP_FIND), 7, 0);   settle();
        send(int'(OP_UNION), 4, 3);  settle();
        send(int'(OP_UNION), 9, 4);  settle();
        send(int'(OP_UNION), 2, 9);  settle();
        send(int'(OP_FIND), 9, 0);   settle();
        send(int'(OP_UNION), 0, 12); settle();
        send(int'(OP_FIND), 12, 0);  settle();
        send(int'(OP_NOP), 3, 3);    settle();

        // Out-of-range label, then back-to-back bad + good requests
        send(int'(OP_FIND), N, 0);   settle();
        clear_err();
        send(int'(OP_UNION), 5, 255);
        send(int'(OP_FIND), 9, 0);
        settle();
        clear_err();

        // Build a 3-hop path 9->3->2->1 and reset in the middle of walking it
        send(int'(OP_UNION), 1, 2);  settle();
        fq.push_back({OP_FIND, 8'(9), 8'(0)});
        fifo_empty = 1'b0;
        n = 0;
        while (rd_q.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_pop_seen", rd_q.size(), 1);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 1);
        chk("abort_res_valid", int'(res_valid), 0);
        rst_n = 1'b1;
        count_clear("abort_clear_cycles");
        chk("abort_no_resp", resp_q.size(), 0);
        rd_q.delete();
        m_clear();
        m_err = 1'b0;
        send(int'(OP_FIND), 9, 0);  settle();
        send(int'(OP_FIND), 2, 0);  settle();
        send(int'(OP_FIND), 3, 0);  settle();

        // Random stream against the model
        for (int it = 0; it < 1200; it++) begin
            nreq = ($urandom_range(3) == 0) ? 2 : 1;
            for (int j = 0; j < nreq; j++) begin
                k = $urandom_range(199);
                a = $urandom_range(N - 1);
                b = $urandom_range(N - 1);
                if (k < 90)       op = int'(OP_FIND);
                else if (k < 180) op = int'(OP_UNION);
                else if (k < 190) op = int'(OP_NOP);
                else if (k < 197) begin
                    op = ($urandom_range(1) == 0) ? int'(OP_FIND) : int'(OP_UNION);
                    if ($urandom_range(1) == 0) a = $urandom_range(255, N);
                    else b = $urandom_range(255, N);
                end
                else op = int'(OP_CLEAR);
                send(op, a, b);
            end
            settle();
            if (m_err && $urandom_range(1) == 0) clear_err();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
